// File: rtl/dnnbp_pkg.sv
// Shared constants and types for the DNN back-prop datapath blocks.
// Q8.24 word format, layer sequencer state encoding, index-width helper.
package dnnbp_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perceptron_seq.sv
// Time-multiplexes one external perceptron across NEURON neurons of a layer,
// fetching per-neuron weights/bias from a synchronous weight memory.
module perceptron_seq
  import dnnbp_pkg::*;
#(
  parameter int unsigned NUM      = 2,
  parameter int unsigned WIDTH    = dnnbp_pkg::WIDTH,
  parameter int unsigned NEURON   = 4,
  parameter int unsigned PERC_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM*WIDTH-1:0]          i_k,
  output logic                          busy,
  output logic                          done,
  output logic [NEURON*WIDTH-1:0]       o_y,
  output logic [idx_w(NEURON)-1:0]      mem_addr,
  output logic                          mem_rd,
  input  logic [(NUM+1)*WIDTH-1:0]      mem_data,
  output logic                          p_wr,
  output logic [NUM*WIDTH-1:0]          p_k,
  output logic [NUM*WIDTH-1:0]          p_w,
  output logic [WIDTH-1:0]              p_b,
  input  logic [WIDTH-1:0]              p_o
);

  localparam int unsigned AW = idx_w(NEURON);
  localparam int unsigned CW = idx_w(PERC_LAT);
  localparam logic [AW-1:0] LAST_N   = AW'(NEURON - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(PERC_LAT - 1);

  seq_state_e            state_q, state_d;
  logic [AW-1:0]         n_q, n_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM*WIDTH-1:0]  w_q;
  logic [WIDTH-1:0]      b_q;

  // Next-state, neuron index and wait counter.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          n_d     = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (PERC_LAT == 1) begin
          state_d = STORE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = STORE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STORE: begin
        if (n_q == LAST_N) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          n_d     = n_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      p_wr     <= 1'b0;
      mem_addr <= '0;
      p_k      <= '0;
      w_q      <= '0;
      b_q      <= '0;
      o_y      <= '0;
    end else begin
      busy   <= (state_d != IDLE);
      done   <= (state_d == DONE);
      mem_rd <= (state_d == FETCH);
      p_wr   <= (state_d == LOAD);
      if (state_d == FETCH) begin
        mem_addr <= n_d;
      end
      if (state_q == IDLE && start) begin
        p_k <= i_k;
      end
      if (state_q == LOAD) begin
        w_q <= mem_data[NUM*WIDTH-1:0];
        b_q <= mem_data[NUM*WIDTH +: WIDTH];
      end
      for (int unsigned s = 0; s < NEURON; s++) begin
        if (state_q == STORE && n_q == AW'(s)) begin
          o_y[s*WIDTH +: WIDTH] <= p_o;
        end
      end
    end
  end

  // Memory read data reaches the perceptron in the LOAD cycle itself, then held.
  assign p_w = (state_q == LOAD) ? mem_data[NUM*WIDTH-1:0]       : w_q;
  assign p_b = (state_q == LOAD) ? mem_data[NUM*WIDTH +: WIDTH]  : b_q;

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: four instances with different NEURON /
// PERC_LAT, each with a weight-memory model and a latency-exact perceptron model.
module tb_perceptron_seq;

  localparam logic [31:0] BAD = 32'hDEADBEEF;
  localparam logic [63:0] K1  = {32'h00800000, 32'h01000000};
  localparam logic [63:0] K2  = {32'h01000000, 32'h02000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] i_k;
  int          errors = 0;
  int          checks = 0;

  logic         start_a, busy_a, done_a, rd_a, wr_a;
  logic [127:0] oy_a;
  logic [1:0]   addr_a;
  logic [95:0]  md_a;
  logic [63:0]  pk_a, pw_a;
  logic [31:0]  pb_a, po_a, pipe_a;

  logic         start_b, busy_b, done_b, rd_b, wr_b;
  logic [63:0]  oy_b;
  logic [0:0]   addr_b;
  logic [95:0]  md_b;
  logic [63:0]  pk_b, pw_b;
  logic [31:0]  pb_b, po_b;
  logic [31:0]  pipe_b [3];

  logic         start_c, busy_c, done_c, rd_c, wr_c;
  logic [31:0]  oy_c;
  logic [0:0]   addr_c;
  logic [95:0]  md_c;
  logic [63:0]  pk_c, pw_c;
  logic [31:0]  pb_c, po_c, pipe_c;

  logic         start_d, busy_d, done_d, rd_d, wr_d;
  logic [127:0] oy_d;
  logic [1:0]   addr_d;
  logic [95:0]  md_d;
  logic [63:0]  pk_d, pw_d;
  logic [31:0]  pb_d, po_d;
  logic [31:0]  pipe_d [2];

  logic [95:0] mem_a [4];
  logic [95:0] mem_b [2];
  logic [95:0] mem_c [1];
  logic [95:0] mem_d [4];

  perceptron_seq #(.NUM(2), .WIDTH(32), .NEURON(4), .PERC_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .i_k(i_k), .busy(busy_a), .done(done_a),
    .o_y(oy_a), .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(md_a), .p_wr(wr_a),
    .p_k(pk_a), .p_w(pw_a), .p_b(pb_a), .p_o(po_a));

  perceptron_seq #(.NUM(2), .WIDTH(32), .NEURON(2), .PERC_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .i_k(i_k), .busy(busy_b), .done(done_b),
    .o_y(oy_b), .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(md_b), .p_wr(wr_b),
    .p_k(pk_b), .p_w(pw_b), .p_b(pb_b), .p_o(po_b));

  perceptron_seq #(.NUM(2), .WIDTH(32), .NEURON(1), .PERC_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .i_k(i_k), .busy(busy_c), .done(done_c),
    .o_y(oy_c), .mem_addr(addr_c), .mem_rd(rd_c), .mem_data(md_c), .p_wr(wr_c),
    .p_k(pk_c), .p_w(pw_c), .p_b(pb_c), .p_o(po_c));

  perceptron_seq #(.NUM(2), .WIDTH(32), .NEURON(4), .PERC_LAT(2)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .i_k(i_k), .busy(busy_d), .done(done_d),
    .o_y(oy_d), .mem_addr(addr_d), .mem_rd(rd_d), .mem_data(md_d), .p_wr(wr_d),
    .p_k(pk_d), .p_w(pw_d), .p_b(pb_d), .p_o(po_d));

  // Reference perceptron: sum of Q8.24 products plus bias, no activation.
  function automatic logic [31:0] perc(input logic [63:0] k, input logic [63:0] w,
                                       input logic [31:0] b);
    longint acc, k0, k1, w0, w1;
    logic [63:0] r;
    k0  = longint'($signed(k[31:0]));
    k1  = longint'($signed(k[63:32]));
    w0  = longint'($signed(w[31:0]));
    w1  = longint'($signed(w[63:32]));
    acc = longint'($signed(b)) + ((k0 * w0) >>> 24) + ((k1 * w1) >>> 24);
    r   = 64'(acc);
    return r[31:0];
  endfunction

  // Memories answer one cycle after mem_rd; perceptron output is valid only
  // exactly PERC_LAT cycles after p_wr, BAD at every other cycle.
  always @(posedge clk) begin
    if (rd_a) md_a <= mem_a[addr_a];
    if (rd_b) md_b <= mem_b[addr_b];
    if (rd_c) md_c <= mem_c[0];
    if (rd_d) md_d <= mem_d[addr_d];
    pipe_a    <= wr_a ? perc(pk_a, pw_a, pb_a) : BAD;
    pipe_b[0] <= wr_b ? perc(pk_b, pw_b, pb_b) : BAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_c    <= wr_c ? perc(pk_c, pw_c, pb_c) : BAD;
    pipe_d[0] <= wr_d ? perc(pk_d, pw_d, pb_d) : BAD;
    pipe_d[1] <= pipe_d[0];
  end

  assign po_a = pipe_a;
  assign po_b = pipe_b[2];
  assign po_c = pipe_c;
  assign po_d = pipe_d[1];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  // Pulse start in the current cycle (cycle 0) and follow the run to done.
  task automatic run(input int which, output int t_done, output int n_wr,
                     output int n_rd, output bit addr_nz);
    logic dn, wr, rd, nz;
    t_done  = -1;
    n_wr    = 0;
    n_rd    = 0;
    addr_nz = 1'b0;
    set_start(which, 1'b1);
    for (int t = 1; t <= 60; t++) begin
      step();
      set_start(which, 1'b0);
      case (which)
        0: begin dn = done_a; wr = wr_a; rd = rd_a; nz = (addr_a != 2'd0); end
        1: begin dn = done_b; wr = wr_b; rd = rd_b; nz = (addr_b != 1'd0); end
        2: begin dn = done_c; wr = wr_c; rd = rd_c; nz = (addr_c != 1'd0); end
        default: begin dn = done_d; wr = wr_d; rd = rd_d; nz = (addr_d != 2'd0); end
      endcase
      if (wr) n_wr++;
      if (rd) n_rd++;
      if (nz) addr_nz = 1'b1;
      if (dn) begin
        t_done = t;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rq();
    return 32'($urandom_range(0, 32'h04FFFFFF)) - 32'h02000000;
  endfunction

  initial begin
    int t_done, n_wr, n_rd, first_done, second_done;
    bit addr_nz;
    logic [63:0] rk;
    logic [31:0] exp_y [4];

    rst = 1'b1;
    i_k = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    for (int n = 0; n < 4; n++) begin
      mem_a[n] = {32'h0, 32'h00400000, 32'(n)};
      mem_d[n] = {32'h0, 32'h01000000, 32'(n + 1) << 24};
    end
    mem_b[0] = {32'h00100000, 32'h01000000, 32'h02000000};
    mem_b[1] = {32'hFFC00000, 32'h00800000, 32'hFF000000};
    mem_c[0] = {32'h00080000, 32'h00C00000, 32'hFF800000};

    repeat (3) step();
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_done", 128'(done_a), 128'(0));
    check("rst_ctl", 128'({rd_a, wr_a, addr_a}), 128'(0));
    check("rst_oy", oy_a, 128'(0));
    check("rst_pk_pw_pb", 128'({pk_a, pw_a, pb_a}), 128'(0));
    rst = 1'b0;
    step();

    // Basic run on four neurons, single-cycle perceptron.
    i_k = K1;
    run(0, t_done, n_wr, n_rd, addr_nz);
    check("a_done_cycle", 128'(t_done), 128'(13));
    check("a_pwr_count", 128'(n_wr), 128'(4));
    check("a_memrd_count", 128'(n_rd), 128'(4));
    for (int n = 0; n < 4; n++)
      check($sformatf("a_slot%0d", n), 128'(oy_a[n*32 +: 32]), 128'(32'h00200000 + 32'(n)));
    step();
    check("a_busy_after", 128'({busy_a, done_a}), 128'(0));

    // Three-cycle perceptron: early p_o is BAD and must not be captured.
    run(1, t_done, n_wr, n_rd, addr_nz);
    check("b_done_cycle", 128'(t_done), 128'(11));
    check("b_pwr_count", 128'(n_wr), 128'(2));
    check("b_slot0", 128'(oy_b[31:0]), 128'(32'h02900000));
    check("b_slot1", 128'(oy_b[63:32]), 128'(32'hFF000000));
    step();

    // Single neuron edge.
    run(2, t_done, n_wr, n_rd, addr_nz);
    check("c_done_cycle", 128'(t_done), 128'(4));
    check("c_addr_zero", 128'(addr_nz), 128'(0));
    check("c_pwr_count", 128'(n_wr), 128'(1));
    check("c_slot0", 128'(oy_c), 128'(32'hFFE80000));
    step();

    // start held high: back-to-back runs, i_k change mid-run ignored.
    i_k = K1;
    start_a = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int t = 1; t <= 60; t++) begin
      step();
      if (t == 1) i_k = K2;
      if (t == 5) check("hold_pk_latched", 128'(pk_a), 128'(K1));
      if (t == 14) check("hold_busy_gap", 128'(busy_a), 128'(0));
      if (done_a) begin
        if (first_done < 0) first_done = t;
        else begin
          second_done = t;
          break;
        end
      end
    end
    start_a = 1'b0;
    check("hold_first_done", 128'(first_done), 128'(13));
    check("hold_second_done", 128'(second_done), 128'(27));
    check("hold_pk_second", 128'(pk_a), 128'(K2));
    check("hold_slot0", 128'(oy_a[31:0]), 128'(32'h00400000));
    check("hold_slot3", 128'(oy_a[127:96]), 128'(32'h00400006));
    step();

    // Reset during WAIT of neuron 2 (cycle 11 with PERC_LAT=2), then a clean run.
    i_k = K1;
    start_d = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      step();
      start_d = 1'b0;
    end
    check("d_busy_pre", 128'(busy_d), 128'(1));
    check("d_slot1_pre", 128'(oy_d[63:32]), 128'(32'h02800000));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("d_rst_busy_done", 128'({busy_d, done_d}), 128'(0));
    check("d_rst_oy", oy_d, 128'(0));
    check("d_rst_pwr", 128'(wr_d), 128'(0));
    run(3, t_done, n_wr, n_rd, addr_nz);
    check("d_done_cycle", 128'(t_done), 128'(17));
    for (int n = 0; n < 4; n++)
      check($sformatf("d_slot%0d", n), 128'(oy_d[n*32 +: 32]),
            128'((32'(n + 1) << 24) | 32'h00800000));
    step();

    // Random Q8.24 runs against the reference model.
    for (int r = 0; r < 50; r++) begin
      rk = {rq(), rq()};
      i_k = rk;
      for (int n = 0; n < 4; n++) begin
        mem_a[n] = {rq(), rq(), rq()};
        exp_y[n] = perc(rk, mem_a[n][63:0], mem_a[n][95:64]);
      end
      run(0, t_done, n_wr, n_rd, addr_nz);
      if (t_done != 13) check($sformatf("rnd%0d_done", r), 128'(t_done), 128'(13));
      for (int n = 0; n < 4; n++)
        check($sformatf("rnd%0d_slot%0d", r, n), 128'(oy_a[n*32 +: 32]), 128'(exp_y[n]));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_seq.md
# perceptron_seq

Sequencer that time-multiplexes one shared `perceptron` instance (NUM inputs, Q8.24 fixed point) across NEURON neurons of a layer. On `start` it does the following for each neuron in turn:
- latches the layer input vector,
- fetches that neuron's weights and bias from an external synchronous weight memory,
- strobes the perceptron,
- captures its result into an output vector.

It sits between the layer-level network controller and the perceptron datapath. It is the building block for multi-neuron layers without replicating multipliers.

## Interface
Parameters:
- NUM, 2, inputs per neuron (perceptron fan-in)
- WIDTH, 32, data word width, Q8.24 signed
- NEURON, 4, neurons sequenced per layer (≥1)
- PERC_LAT, 1, perceptron latency from `wr` cycle to valid `o` (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer evaluation; accepted only in IDLE
- i_k  in  NUM*WIDTH  layer input vector; sampled on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, layer complete
- o_y  out  NEURON*WIDTH  results; slot n = bits [n*WIDTH +: WIDTH]
- mem_addr  out  clog2(NEURON) (min 1)  weight-memory address = neuron index
- mem_rd  out  1  read enable
- mem_data  in  (NUM+1)*WIDTH  read data, valid the cycle after mem_rd; bias in top WIDTH bits, weight j in [j*WIDTH +: WIDTH]
- p_wr  out  1  perceptron operand strobe
- p_k  out  NUM*WIDTH  to perceptron `i_k` (latched input vector)
- p_w  out  NUM*WIDTH  to perceptron `i_w`
- p_b  out  WIDTH  to perceptron `i_b`
- p_o  in  WIDTH  from perceptron `o`

## Operation
States: IDLE, FETCH, LOAD, WAIT, STORE, DONE. Neuron index n and wait counter are internal.

- IDLE: `start` → latch `i_k` into `p_k`, set n=0, go to FETCH. Otherwise stay.
- FETCH: `mem_rd`=1, `mem_addr`=n → LOAD.
- LOAD: `p_w`/`p_b` driven from `mem_data` (registered this cycle and held), `p_wr`=1.
  - PERC_LAT=1 → STORE.
  - Otherwise → WAIT with counter = PERC_LAT-1.
- WAIT: decrement the counter; at 1 → STORE. Occupies PERC_LAT-1 cycles.
- STORE: capture `p_o` into `o_y` slot n.
  - n=NEURON-1 → DONE.
  - Otherwise n++ and → FETCH.
- DONE: `done`=1 → IDLE.

Rules:
- `start` outside IDLE (including the DONE cycle) is ignored.
- `i_k` changes after acceptance do not affect the run.
- `o_y` slots not yet written keep their previous-run values. A slot updates only in its STORE cycle.
- No arithmetic is performed here. Values pass through bit-exact; no saturation or rounding.
- `p_k`, `p_w`, `p_b` hold their values outside LOAD.

## Timing
- Reset (synchronous, any state including mid-run):
  - state = IDLE, n = 0.
  - `busy`, `done`, `mem_rd`, `p_wr` = 0.
  - `o_y`, `p_k`, `p_w`, `p_b`, `mem_addr` = 0.
  - Takes effect at the next edge. A `start` in the reset cycle is ignored.
- Per neuron: PERC_LAT+2 cycles (FETCH, LOAD, WAIT×(PERC_LAT-1), STORE).
- Start accepted in cycle 0 → `done` high in cycle NEURON*(PERC_LAT+2)+1. The earliest next start is accepted in the following cycle (IDLE).
- `busy` rises the cycle after start acceptance and falls the cycle after DONE.
- `p_wr` is high exactly NEURON times per run, each time for 1 cycle.
- `mem_rd` is high exactly NEURON times per run, each time 1 cycle before the corresponding `p_wr`.
- `p_o` is sampled exactly PERC_LAT cycles after each `p_wr` cycle.

## Structure
- Shared package `dnnbp_pkg`:
  - WIDTH=32, FRAC=24 constants.
  - State enum (IDLE, FETCH, LOAD, WAIT, STORE, DONE).
- No sub-module inside. The `perceptron` and the weight memory are instantiated by the parent and wired to `p_*`/`mem_*`. Keeping the perceptron outside the sequencer allows sharing and swapping.

## Test plan
Each directed scenario is listed as stimulus → required response.

- Basic run, NUM=2, NEURON=4, PERC_LAT=1, behavioural perceptron model, k=(1.0, 0.5)=(0x01000000, 0x00800000), neuron n weights=(n, 0x00400000), bias 0 → `o_y` slots match the model; `done` at cycle 13; 4 `p_wr` pulses.
- PERC_LAT=3, NEURON=2 → `done` at cycle 11; `p_o` sampled 3 cycles after each `p_wr`. A wrong-valued `p_o` injected 1 cycle early must not be captured.
- `start` held high continuously → runs back-to-back: second start accepted the cycle after `done`, never in DONE; `i_k` change mid-run does not alter `p_k`.
- `rst` asserted in WAIT of neuron 2 → next cycle: IDLE, `busy`=0, `o_y`=0, `p_wr`=0. A fresh start then completes normally.
- NEURON=1 edge → `mem_addr` stays 0; `done` at cycle 4.
- Random Q8.24 values (integer part -2..2) over 50 runs against the reference model → bit-exact `o_y`.
